// File: rtl/csr_pipeline_ctrl_pkg.sv
// Shared CSR address constants, redirect-sensitivity bit positions and trap FSM states
// for the CSR pipeline glue.
package csr_pipeline_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;

    localparam int unsigned SENS_MTVEC   = 0;
    localparam int unsigned SENS_MSTATUS = 1;
    localparam int unsigned SENS_MIE     = 2;
    localparam int unsigned SENS_MEPC    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FIRE = 2'd2
    } trap_state_e;

    // True when a write to addr could change where (or whether) a trap redirects.
    function automatic logic is_sens_addr(input logic [11:0] addr, input logic [3:0] mask);
        case (addr)
            CSR_MTVEC:   return mask[SENS_MTVEC];
            CSR_MSTATUS: return mask[SENS_MSTATUS];
            CSR_MIE:     return mask[SENS_MIE];
            CSR_MEPC:    return mask[SENS_MEPC];
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_pipeline_ctrl_irq_sync_latch.sv
// Per-line interrupt synchroniser with rising-edge detect and an ack-cleared pending latch.
module irq_sync_latch
    import csr_pipeline_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_raw,
    input  logic [NUM_IRQ-1:0] irq_ack,
    output logic [NUM_IRQ-1:0] irq_pending
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] rise;

    assign rise        = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign irq_pending = pend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            sync_q[0] <= irq_raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            // A fresh edge beats an ack arriving in the same cycle.
            pend_q <= (pend_q & ~irq_ack) | rise;
        end
    end

endmodule

// File: rtl/csr_pipeline_ctrl.sv
// Commit-ordered glue between the 5-stage pipeline and csr_unit: EX read forwarding,
// WB-only commits, trap redirect hold while sensitive CSR writes drain, and irq latching.
module csr_pipeline_ctrl
    import csr_pipeline_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_HOLD    = 4,
    parameter logic [3:0]  SENS_MASK   = 4'b1111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_v,
    input  logic               mem_v,
    input  logic               wb_v,
    input  logic               csr_is_ex,
    input  logic [11:0]        csr_addr_ex,
    input  logic               csr_is_mem,
    input  logic [11:0]        csr_addr_mem,
    input  logic [XLEN-1:0]    csr_newval_mem,
    input  logic               csr_is_wb,
    input  logic [2:0]         csr_cmd_wb,
    input  logic [11:0]        csr_addr_wb,
    input  logic [XLEN-1:0]    csr_newval_wb,
    input  logic               is_mret_wb,
    input  logic               kill_wb,
    input  logic               take_trap_raw,
    input  logic [XLEN-1:0]    trap_cause_in,
    input  logic [XLEN-1:0]    trap_pc_in,
    input  logic [NUM_IRQ-1:0] irq_raw,
    input  logic [NUM_IRQ-1:0] irq_ack,
    input  logic [XLEN-1:0]    u_csr_rdata,
    output logic               u_csr_en,
    output logic [2:0]         u_csr_cmd,
    output logic [11:0]        u_csr_addr,
    output logic [XLEN-1:0]    u_csr_wdata,
    output logic               u_mret,
    output logic [XLEN-1:0]    csr_rdata_ex,
    output logic               take_trap,
    output logic [XLEN-1:0]    trap_cause_out,
    output logic [XLEN-1:0]    trap_pc_out,
    output logic               trap_busy,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               intr_any,
    output logic               hold_timeout
);

    localparam int unsigned       CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic commit;
    logic ex_rd;
    logic mem_hit;
    logic wb_hit;
    logic mem_sens;
    logic wb_sens;
    logic pend_sens;

    trap_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   cause_q, pc_q;
    logic              timeout_q;
    logic              latch_en;
    logic              set_timeout;

    assign commit      = wb_v & csr_is_wb & ~kill_wb;
    assign u_csr_en    = commit;
    assign u_csr_cmd   = csr_cmd_wb;
    assign u_csr_wdata = csr_newval_wb;
    assign u_mret      = wb_v & is_mret_wb & ~kill_wb;
    assign u_csr_addr  = commit ? csr_addr_wb : csr_addr_ex;

    // MEM is younger than WB, so its pending value shadows the WB commit.
    assign ex_rd   = ex_v & csr_is_ex;
    assign mem_hit = ex_rd & mem_v & csr_is_mem & (csr_addr_mem == csr_addr_ex);
    assign wb_hit  = ex_rd & commit & (csr_addr_wb == csr_addr_ex);

    always_comb begin
        csr_rdata_ex = u_csr_rdata;
        if (mem_hit) begin
            csr_rdata_ex = csr_newval_mem;
        end else if (wb_hit) begin
            csr_rdata_ex = csr_newval_wb;
        end
    end

    assign mem_sens  = mem_v & csr_is_mem & is_sens_addr(csr_addr_mem, SENS_MASK);
    assign wb_sens   = commit & is_sens_addr(csr_addr_wb, SENS_MASK);
    assign pend_sens = mem_sens | wb_sens;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        latch_en       = 1'b0;
        set_timeout    = 1'b0;
        take_trap      = 1'b0;
        trap_cause_out = cause_q;
        trap_pc_out    = pc_q;
        case (state_q)
            IDLE: begin
                trap_cause_out = trap_cause_in;
                trap_pc_out    = trap_pc_in;
                if (take_trap_raw) begin
                    if (pend_sens) begin
                        latch_en = 1'b1;
                        cnt_d    = '0;
                        state_d  = HOLD;
                    end else begin
                        take_trap = 1'b1;
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!pend_sens) begin
                    state_d = FIRE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d     = FIRE;
                    set_timeout = 1'b1;
                end
            end
            FIRE: begin
                take_trap = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cause_q   <= '0;
            pc_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                cause_q <= trap_cause_in;
                pc_q    <= trap_pc_in;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign trap_busy    = (state_q != IDLE);
    assign hold_timeout = timeout_q;

    // The arbiter must wait for trap_busy to drop before raising another request.
    a_no_req_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(take_trap_raw && (state_q != IDLE)));

    irq_sync_latch #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq (
        .clk         (clk),
        .reset       (reset),
        .irq_raw     (irq_raw),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending)
    );

    assign intr_any = |irq_pending;

endmodule
